// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (imem) and data (dmem)
// request ports. Keeps one request outstanding and one pending request per port.
// dmem has priority, except that imem is forced through after STARVE_LIMIT
// consecutive dmem grants that were made while imem was waiting.
//
// state  | meaning
// IDLE   | no request outstanding on the memory port
// BUSY_I | fetch request outstanding, waiting for mem_resp
// BUSY_D | load/store request outstanding, waiting for mem_resp
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t             state;
  logic               i_pend;
  logic [31:0]        i_addr;
  logic [3:0]         i_rmask;
  logic               d_pend;
  logic [31:0]        d_addr;
  logic [3:0]         d_rmask;
  logic [3:0]         d_wmask;
  logic [31:0]        d_wdata;
  logic [CNT_W-1:0]   starve_cnt;

  logic               new_i;
  logic               new_d;
  logic               i_cand;
  logic               d_cand;
  logic [31:0]        ci_addr;
  logic [3:0]         ci_rmask;
  logic [31:0]        cd_addr;
  logic [3:0]         cd_rmask;
  logic [3:0]         cd_wmask;
  logic [31:0]        cd_wdata;
  logic               arb_en;
  logic               at_limit;
  logic               grant_i;
  logic               grant_d;

  assign new_i = |imem_rmask;
  assign new_d = (|dmem_rmask) | (|dmem_wmask);

  // Candidate selection: a pending buffer takes precedence over a same-cycle request
  // (a same-cycle request on a pending port is a protocol error and is dropped).
  always_comb begin
    i_cand   = i_pend | new_i;
    d_cand   = d_pend | new_d;
    ci_addr  = i_pend ? i_addr  : imem_addr;
    ci_rmask = i_pend ? i_rmask : imem_rmask;
    cd_addr  = d_pend ? d_addr  : dmem_addr;
    cd_rmask = d_pend ? d_rmask : dmem_rmask;
    cd_wmask = d_pend ? d_wmask : dmem_wmask;
    cd_wdata = d_pend ? d_wdata : dmem_wdata;
    // Arbitrate when the port is free now or frees up this cycle (zero-bubble handoff).
    arb_en   = (state == IDLE) | mem_resp;
    at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_d  = arb_en & d_cand & ~(i_cand & at_limit);
    grant_i  = arb_en & i_cand & ~grant_d;
  end

  // Responses are steered combinationally to the port that owns the outstanding request.
  assign imem_resp  = (state == BUSY_I) & mem_resp;
  assign dmem_resp  = (state == BUSY_D) & mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

  // Arbitration FSM with pending-buffer capture, starvation counter and registered mem port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      i_pend     <= 1'b0;
      i_addr     <= '0;
      i_rmask    <= '0;
      d_pend     <= 1'b0;
      d_addr     <= '0;
      d_rmask    <= '0;
      d_wmask    <= '0;
      d_wdata    <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_rmask  <= '0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_rmask <= '0;
      mem_wmask <= '0;

      if (grant_i) begin
        i_pend <= 1'b0;
      end else if (new_i && !i_pend) begin
        i_pend  <= 1'b1;
        i_addr  <= imem_addr;
        i_rmask <= imem_rmask;
      end

      if (grant_d) begin
        d_pend <= 1'b0;
      end else if (new_d && !d_pend) begin
        d_pend  <= 1'b1;
        d_addr  <= dmem_addr;
        d_rmask <= dmem_rmask;
        d_wmask <= dmem_wmask;
        d_wdata <= dmem_wdata;
      end

      if (grant_d) begin
        mem_addr  <= cd_addr;
        mem_rmask <= cd_rmask;
        mem_wmask <= cd_wmask;
        mem_wdata <= cd_wdata;
        state     <= BUSY_D;
        if (i_cand && !at_limit) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end else if (grant_i) begin
        mem_addr   <= ci_addr;
        mem_rmask  <= ci_rmask;
        state      <= BUSY_I;
        starve_cnt <= '0;
      end else if (arb_en) begin
        state <= IDLE;
      end
    end
  end

  // A port must not re-request while its previous request is still pending.
  a_no_imem_rereq: assert property (@(posedge clk) disable iff (!rst) !(i_pend && new_i));
  a_no_dmem_rereq: assert property (@(posedge clk) disable iff (!rst) !(d_pend && new_d));

endmodule
